fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PROGRAM_MEM_ADDR_BITS, default 8: program memory address width.
REQ-002 SHALL have parameter PROGRAM_MEM_DATA_BITS, default 16: instruction width.
REQ-003 SHALL have parameter CACHE_ENTRIES, default 4, power of two >= 2: instruction cache depth.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port core_state  in  3  scheduler state: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
REQ-007 SHALL have port current_pc  in  ADDR_BITS  address of the instruction to fetch.
REQ-008 SHALL have port flush  in  1  invalidate all cache entries.
REQ-009 SHALL have port mem_read_valid  out  1  program memory read request.
REQ-010 SHALL have port mem_read_address  out  ADDR_BITS  request address.
REQ-011 SHALL have port mem_read_ready  in  1  read data valid / request accepted.
REQ-012 SHALL have port mem_read_data  in  DATA_BITS  returned instruction.
REQ-013 SHALL have port fetcher_state  out  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010.
REQ-014 SHALL have port instruction  out  DATA_BITS  fetched instruction, stable while FETCHED.

Function
REQ-015 SHALL implement FSM IDLE -> FETCHING -> FETCHED -> IDLE, with fetcher_state equal to the current FSM state.
REQ-016 In IDLE with core_state==FETCH and a cache miss, SHALL assert mem_read_valid, drive mem_read_address=current_pc, and go to FETCHING on the same edge.
REQ-017 In FETCHING, SHALL hold mem_read_valid=1 and mem_read_address stable until an edge samples mem_read_ready=1.
REQ-018 On that edge, SHALL load instruction=mem_read_data, deassert mem_read_valid, and go to FETCHED.
REQ-019 Miss latency SHALL be FETCH sampled at edge N, valid high after N, FETCHED one edge after ready is sampled.
REQ-020 SHALL ignore mem_read_ready when mem_read_valid=0.
REQ-021 In FETCHED, SHALL hold instruction and go to IDLE on the edge sampling core_state==DECODE; any other core_state keeps FETCHED.
REQ-022 In IDLE, any core_state other than FETCH SHALL leave all outputs unchanged.
REQ-023 Cache SHALL be direct-mapped: index=current_pc[log2(CACHE_ENTRIES)-1:0], tag=remaining upper PC bits, one valid bit per entry.
REQ-024 In IDLE with core_state==FETCH and a hit, SHALL load instruction from the cache and go directly to FETCHED in one edge with no memory request.
REQ-025 On the memory-response edge (REQ-018), SHALL write data, tag and valid=1 into the indexed entry, overwriting any prior occupant.
REQ-026 flush=1 SHALL clear all valid bits on that edge; on a simultaneous fill, flush wins and the entry stays invalid.
REQ-027 flush SHALL NOT abort an outstanding FETCHING request; that request completes and delivers its data.
REQ-028 flush sampled together with an IDLE FETCH lookup SHALL force a miss.

Reset
REQ-029 While reset=1, regardless of clk, SHALL force FSM=IDLE, fetcher_state=000, mem_read_valid=0, mem_read_address=0, instruction=0, and all cache valid bits=0.
REQ-030 Reset asserted mid-FETCHING SHALL drop the request immediately; a later mem_read_ready SHALL be ignored.

Configuration
REQ-031 Macro FETCH_UNIT_CACHE_EN SHALL enable the cache, flush and hit path (REQ-023..REQ-028).
REQ-032 Without FETCH_UNIT_CACHE_EN, every FETCH SHALL miss and issue a memory read, flush SHALL be ignored, and no cache storage SHALL be built.

Verification
REQ-033 Miss: pc=0x05, FETCH, ready after 3 cycles with data 0x9123 -> valid/address held 3 cycles, then FETCHED, instruction=0x9123.
REQ-034 Handshake: after FETCHED, hold core_state=FETCH 4 cycles then DECODE -> stays FETCHED 4 cycles, IDLE after the DECODE edge, no second request.
REQ-035 Hit (macro on): fetch 0x05, then FETCH 0x05 again -> FETCHED one edge later, mem_read_valid never asserted, instruction=0x9123.
REQ-036 Conflict (macro on, 4 entries): fetch 0x01 then 0x05 then 0x01 -> all three miss, each returns its own data.
REQ-037 Flush (macro on): cache 0x05, pulse flush, FETCH 0x05 -> miss; flush coincident with a fill -> next FETCH of that PC misses.
REQ-038 Reset mid-FETCHING: assert reset between clock edges -> mem_read_valid=0 and fetcher_state=000 immediately; a later ready pulse is ignored; macro off -> every repeat FETCH issues a read.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : instruction fetcher with optional direct-mapped I-cache      |
// |              (build with FETCH_UNIT_CACHE_EN to enable cache and flush).  |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_ENTRIES         = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  localparam logic [2:0] CORE_FETCH  = 3'd1;
  localparam logic [2:0] CORE_DECODE = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_FETCHING = 3'b001,
    ST_FETCHED  = 3'b010
  } state_e;

  state_e                             state_q, state_d;
  logic                               mem_read_valid_q, mem_read_valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   mem_read_address_q, mem_read_address_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   instruction_q, instruction_d;
  logic                               fill_en;
  logic                               hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   hit_data;

`ifdef FETCH_UNIT_CACHE_EN
  localparam int IDX_BITS = $clog2(CACHE_ENTRIES);
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  logic [CACHE_ENTRIES-1:0]         valid_q;
  logic [TAG_BITS-1:0]              tag_q  [CACHE_ENTRIES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] data_q [CACHE_ENTRIES];
  logic [IDX_BITS-1:0]              lkp_idx, fill_idx;
  logic [TAG_BITS-1:0]              lkp_tag, fill_tag;

  assign lkp_idx  = current_pc[IDX_BITS-1:0];
  assign lkp_tag  = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
  // The fill is tagged with the address actually requested, not the live PC.
  assign fill_idx = mem_read_address_q[IDX_BITS-1:0];
  assign fill_tag = mem_read_address_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];

  assign hit      = !flush && valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign hit_data = data_q[lkp_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_read_data;
    end
  end
`else
  logic unused_cache_sigs;

  assign hit               = 1'b0;
  assign hit_data          = '0;
  assign unused_cache_sigs = flush ^ fill_en;
`endif

  always_comb begin
    state_d            = state_q;
    mem_read_valid_d   = mem_read_valid_q;
    mem_read_address_d = mem_read_address_q;
    instruction_d      = instruction_q;
    fill_en            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (hit) begin
            instruction_d = hit_data;
            state_d       = ST_FETCHED;
          end else begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = current_pc;
            state_d            = ST_FETCHING;
          end
        end
      end
      ST_FETCHING: begin
        if (mem_read_ready) begin
          instruction_d    = mem_read_data;
          mem_read_valid_d = 1'b0;
          fill_en          = 1'b1;
          state_d          = ST_FETCHED;
        end
      end
      ST_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d          = ST_IDLE;
        mem_read_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      mem_read_valid_q   <= 1'b0;
      mem_read_address_q <= '0;
      instruction_q      <= '0;
    end else begin
      state_q            <= state_d;
      mem_read_valid_q   <= mem_read_valid_d;
      mem_read_address_q <= mem_read_address_d;
      instruction_q      <= instruction_d;
    end
  end

  assign fetcher_state    = state_q;
  assign mem_read_valid   = mem_read_valid_q;
  assign mem_read_address = mem_read_address_q;
  assign instruction      = instruction_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : directed self-checking bench for fetch_unit               |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16),
    .CACHE_ENTRIES(4)
  ) dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .flush(flush), .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state), .instruction(instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cs;
    logic [7:0]  pc;
    logic        rdy;
    logic [15:0] data;
    logic [2:0]  e_st;
    logic        e_v;
    logic [7:0]  e_addr;
    logic [15:0] e_instr;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_miss(input logic [7:0] pc, input logic [15:0] data, input int waits);
    core_state = 3'd1; current_pc = pc; mem_read_ready = 1'b0;
    tick();
    check("miss_state", {29'd0, fetcher_state}, 32'd1);
    check("miss_valid", {31'd0, mem_read_valid}, 32'd1);
    check("miss_addr", {24'd0, mem_read_address}, {24'd0, pc});
    core_state = 3'd2;
    for (int i = 0; i < waits; i++) begin
      tick();
      check("miss_hold_valid", {31'd0, mem_read_valid}, 32'd1);
    end
    mem_read_ready = 1'b1; mem_read_data = data;
    tick();
    check("miss_done_state", {29'd0, fetcher_state}, 32'd2);
    check("miss_done_instr", {16'd0, instruction}, {16'd0, data});
    check("miss_done_valid", {31'd0, mem_read_valid}, 32'd0);
    mem_read_ready = 1'b0; mem_read_data = 16'hdead;
    tick();
    check("miss_to_idle", {29'd0, fetcher_state}, 32'd0);
  endtask

  task automatic fetch_hit(input logic [7:0] pc, input logic [15:0] data);
    core_state = 3'd1; current_pc = pc; mem_read_ready = 1'b0;
    tick();
    check("hit_state", {29'd0, fetcher_state}, 32'd2);
    check("hit_valid", {31'd0, mem_read_valid}, 32'd0);
    check("hit_instr", {16'd0, instruction}, {16'd0, data});
    core_state = 3'd2;
    tick();
    check("hit_to_idle", {29'd0, fetcher_state}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; core_state = 3'd0; current_pc = 8'h00; flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    #2;
    check("rst_state", {29'd0, fetcher_state}, 32'd0);
    check("rst_valid", {31'd0, mem_read_valid}, 32'd0);
    check("rst_addr", {24'd0, mem_read_address}, 32'd0);
    check("rst_instr", {16'd0, instruction}, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;

    // Miss with three wait cycles, then a FETCH-held handshake and a DECODE release.
    vecs[0]  = '{3'd0, 8'h05, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h00, 16'h0000};
    vecs[1]  = '{3'd1, 8'h05, 1'b0, 16'h0000, 3'd1, 1'b1, 8'h05, 16'h0000};
    vecs[2]  = '{3'd2, 8'h07, 1'b0, 16'h0000, 3'd1, 1'b1, 8'h05, 16'h0000};
    vecs[3]  = '{3'd2, 8'h07, 1'b0, 16'h0000, 3'd1, 1'b1, 8'h05, 16'h0000};
    vecs[4]  = '{3'd2, 8'h07, 1'b0, 16'h0000, 3'd1, 1'b1, 8'h05, 16'h0000};
    vecs[5]  = '{3'd2, 8'h07, 1'b1, 16'h9123, 3'd2, 1'b0, 8'h05, 16'h9123};
    vecs[6]  = '{3'd1, 8'h09, 1'b1, 16'hdead, 3'd2, 1'b0, 8'h05, 16'h9123};
    vecs[7]  = '{3'd1, 8'h09, 1'b1, 16'hdead, 3'd2, 1'b0, 8'h05, 16'h9123};
    vecs[8]  = '{3'd1, 8'h09, 1'b1, 16'hdead, 3'd2, 1'b0, 8'h05, 16'h9123};
    vecs[9]  = '{3'd1, 8'h09, 1'b1, 16'hdead, 3'd2, 1'b0, 8'h05, 16'h9123};
    vecs[10] = '{3'd2, 8'h09, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h05, 16'h9123};
    vecs[11] = '{3'd4, 8'h33, 1'b1, 16'hbeef, 3'd0, 1'b0, 8'h05, 16'h9123};
`ifdef FETCH_UNIT_CACHE_EN
    vecs[12] = '{3'd1, 8'h05, 1'b0, 16'h0000, 3'd2, 1'b0, 8'h05, 16'h9123};
    vecs[13] = '{3'd2, 8'h05, 1'b1, 16'h4444, 3'd0, 1'b0, 8'h05, 16'h9123};
    vecs[14] = '{3'd2, 8'h05, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h05, 16'h9123};
`else
    vecs[12] = '{3'd1, 8'h05, 1'b0, 16'h0000, 3'd1, 1'b1, 8'h05, 16'h9123};
    vecs[13] = '{3'd2, 8'h05, 1'b1, 16'h4444, 3'd2, 1'b0, 8'h05, 16'h4444};
    vecs[14] = '{3'd2, 8'h05, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h05, 16'h4444};
`endif

    for (int i = 0; i < 15; i++) begin
      core_state = vecs[i].cs; current_pc = vecs[i].pc;
      mem_read_ready = vecs[i].rdy; mem_read_data = vecs[i].data;
      tick();
      check($sformatf("vec%0d_state", i), {29'd0, fetcher_state}, {29'd0, vecs[i].e_st});
      check($sformatf("vec%0d_valid", i), {31'd0, mem_read_valid}, {31'd0, vecs[i].e_v});
      check($sformatf("vec%0d_addr", i), {24'd0, mem_read_address}, {24'd0, vecs[i].e_addr});
      check($sformatf("vec%0d_instr", i), {16'd0, instruction}, {16'd0, vecs[i].e_instr});
    end
    mem_read_ready = 1'b0;

`ifdef FETCH_UNIT_CACHE_EN
    do_reset();
    fetch_miss(8'h05, 16'h9123, 1);
    fetch_hit(8'h05, 16'h9123);
    // Index 1 is shared by 0x01 and 0x05; each must evict the other.
    fetch_miss(8'h01, 16'h1111, 0);
    fetch_miss(8'h05, 16'h5555, 0);
    fetch_miss(8'h01, 16'h1112, 0);
    fetch_hit(8'h01, 16'h1112);
    core_state = 3'd0; flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_miss(8'h01, 16'h2222, 0);
    // Flush during FETCHING must not abort; flush on the fill edge leaves it invalid.
    core_state = 3'd1; current_pc = 8'h22;
    tick();
    core_state = 3'd2; flush = 1'b1;
    tick();
    check("flush_wait_valid", {31'd0, mem_read_valid}, 32'd1);
    mem_read_ready = 1'b1; mem_read_data = 16'h7777;
    tick();
    check("flush_fill_state", {29'd0, fetcher_state}, 32'd2);
    check("flush_fill_instr", {16'd0, instruction}, 32'h7777);
    flush = 1'b0; mem_read_ready = 1'b0;
    tick();
    fetch_miss(8'h22, 16'h7778, 0);
    // A flush coinciding with a lookup forces a miss even on a valid entry.
    core_state = 3'd1; current_pc = 8'h22; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_lookup_state", {29'd0, fetcher_state}, 32'd1);
    check("flush_lookup_valid", {31'd0, mem_read_valid}, 32'd1);
    mem_read_ready = 1'b1; mem_read_data = 16'h7779; core_state = 3'd2;
    tick();
    mem_read_ready = 1'b0;
    tick();
`else
    do_reset();
    fetch_miss(8'h05, 16'h9123, 1);
    fetch_miss(8'h05, 16'h9124, 0);
    core_state = 3'd0; flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_miss(8'h05, 16'h9125, 0);
`endif

    // Asynchronous reset mid-FETCHING drops the request before the next edge.
    core_state = 3'd1; current_pc = 8'h07;
    tick();
    check("pre_rst_valid", {31'd0, mem_read_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, mem_read_valid}, 32'd0);
    check("async_rst_state", {29'd0, fetcher_state}, 32'd0);
    check("async_rst_instr", {16'd0, instruction}, 32'd0);
    @(negedge clk);
    reset = 1'b0; core_state = 3'd0; mem_read_ready = 1'b1; mem_read_data = 16'habcd;
    repeat (2) tick();
    check("post_rst_state", {29'd0, fetcher_state}, 32'd0);
    check("post_rst_instr", {16'd0, instruction}, 32'd0);
    check("post_rst_valid", {31'd0, mem_read_valid}, 32'd0);
    mem_read_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
